cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//   Master state sequencer for the 4-bit-opcode CPU. Generates the one-hot FETCH/EXEC1/EXEC2 strobes
//   consumed by the instruction decoder. Handles 2- vs 3-cycle instructions (EXTRA) and the STP halt.
//   Adds a run/step/pause debug control plus cycle and retired-instruction counters.
//   Sits between the debug/switch inputs and the decoder; IR is supplied by the instruction register.
// PARAMETERS
//   CNT_W         16       width of cycle_count and instr_count
//   RUN_ON_RESET  1        1: leave reset in FETCH, free-running; 0: leave reset in PAUSE
//   STP_OPCODE    4'b0111  opcode that halts the machine
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   IR           in   4      current opcode; valid from EXEC1 onward (loaded at end of FETCH)
//   EXTRA        in   1      from decoder: current instruction needs EXEC2 (sampled in EXEC1 only)
//   run          in   1      level/pulse: enter free-running mode
//   step         in   1      pulse: execute exactly one instruction from PAUSE
//   halt_req     in   1      pulse: stop free-running at the next instruction boundary
//   FETCH        out  1      fetch cycle strobe
//   EXEC1        out  1      first execute cycle strobe
//   EXEC2        out  1      second execute cycle strobe
//   PAUSED       out  1      sequencer idle, awaiting run/step
//   HALTED       out  1      STP executed; only reset exits
//   instr_done   out  1      high in the final execute cycle of each retired instruction
//   cycle_count  out  CNT_W  cycles spent in FETCH/EXEC1/EXEC2, saturating
//   instr_count  out  CNT_W  retired instructions, wrapping
// BEHAVIOUR
//   - States: PAUSE, FETCH, EXEC1, EXEC2, HALT. One-hot registered; FETCH/EXEC1/EXEC2/PAUSED/HALTED
//     are direct flop outputs, exactly one high every cycle.
//   - Internal flag run_mode: set by run, cleared by halt_req or STP.
//   - Reset, cycle after reset deasserts:
//     - RUN_ON_RESET=1: state=FETCH, run_mode=1.
//     - RUN_ON_RESET=0: state=PAUSE, run_mode=0.
//     - Counters = 0, instr_done = 0.
//     - Reset has priority over everything; reset mid-instruction aborts it, no count.
//   - Transitions:
//     - FETCH -> EXEC1 unconditionally.
//     - EXEC1:
//       - IR==STP_OPCODE -> HALT; run_mode cleared. STP priority over EXTRA.
//       - else EXTRA=1 -> EXEC2.
//       - else boundary.
//     - EXEC2 -> boundary.
//     - Boundary: run_mode=1 (after this cycle's halt_req applied) -> FETCH; else -> PAUSE.
//     - PAUSE:
//       - halt_req -> stay.
//       - else run -> FETCH, run_mode=1.
//       - else step -> FETCH, run_mode stays 0.
//       - Priority: halt_req > run > step.
//     - HALT: stays until reset; run/step/halt_req ignored.
//   - halt_req is accepted in any state and clears run_mode the same edge. The current instruction
//     always completes; it never truncates EXEC1/EXEC2.
//   - instr_done is combinational:
//     - (EXEC1 & ~EXTRA & IR!=STP_OPCODE) | EXEC2.
//     - STP does not count as retired; instr_done stays 0 in its EXEC1.
//   - instr_count += 1 on every edge where instr_done=1; wraps 2^CNT_W-1 -> 0.
//   - cycle_count += 1 on every edge in FETCH/EXEC1/EXEC2; holds at 2^CNT_W-1. No count in PAUSE/HALT.
//   - Latency: step pulse in PAUSE -> FETCH next cycle; instruction is 2 or 3 cycles; back to PAUSE
//     the cycle after instr_done.
//   - IR and EXTRA are ignored outside EXEC1.
// TESTING
//   1 RUN_ON_RESET=1, stream of IR=0000 with EXTRA=1:
//     - Required pattern after reset: F,E1,E2,F,E1,E2...
//     - After 9 cycles: cycle_count=9, instr_count=3.
//   2 IR=0100 (EXTRA=0) then IR=0111:
//     - Required: F,E1,F,E1,HALT.
//     - HALTED stays 1 while run/step are toggled for 20 cycles.
//     - Final values: instr_count=1, cycle_count=4.
//   3 RUN_ON_RESET=0, step pulse, EXTRA=1:
//     - Required: PAUSE,F,E1,E2,PAUSE.
//     - instr_done high only in E2.
//     - instr_count=1.
//   4 Running, halt_req in EXEC1 of a 3-cycle instruction:
//     - EXEC2 still occurs, then PAUSE.
//     - A later run in the same cycle as halt_req keeps PAUSE.
//   5 Same-cycle run+step in PAUSE:
//     - run_mode=1; machine free-runs past the first instruction.
//   6 CNT_W=4, 20 two-cycle instructions:
//     - cycle_count saturates at 15.
//     - instr_count wraps to 4.
//     - reset asserted in EXEC1 -> all counters 0 next cycle.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Bus between the debug/decoder environment and the CPU master sequencer.
// The master drives IR/EXTRA/debug controls; the slave (sequencer) drives strobes and counters.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       IR;
    logic             EXTRA;
    logic             run;
    logic             step;
    logic             halt_req;
    logic             FETCH;
    logic             EXEC1;
    logic             EXEC2;
    logic             PAUSED;
    logic             HALTED;
    logic             instr_done;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output IR, EXTRA, run, step, halt_req,
        input  FETCH, EXEC1, EXEC2, PAUSED, HALTED, instr_done, cycle_count, instr_count
    );

    modport slave (
        input  IR, EXTRA, run, step, halt_req,
        output FETCH, EXEC1, EXEC2, PAUSED, HALTED, instr_done, cycle_count, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Master state sequencer: one-hot FETCH/EXEC1/EXEC2 strobes, STP halt, run/step/pause
// debug control, saturating cycle counter and wrapping retired-instruction counter.
module cpu_sequencer #(
    parameter int         CNT_W        = 16,
    parameter bit         RUN_ON_RESET = 1'b1,
    parameter logic [3:0] STP_OPCODE   = 4'b0111
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_sequencer_if.slave        bus
);

    typedef enum logic [4:0] {
        S_PAUSE = 5'b00001,
        S_FETCH = 5'b00010,
        S_EXEC1 = 5'b00100,
        S_EXEC2 = 5'b01000,
        S_HALT  = 5'b10000
    } state_t;

    state_t           state;
    logic             run_mode;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    logic is_stp;
    logic run_mode_nxt;
    logic instr_done;
    logic active;

    assign is_stp       = (bus.IR == STP_OPCODE);
    assign active       = (state == S_FETCH) || (state == S_EXEC1) || (state == S_EXEC2);
    // halt_req wins over a coincident run, so a boundary in the same cycle lands in PAUSE
    assign run_mode_nxt = bus.halt_req ? 1'b0 : (bus.run ? 1'b1 : run_mode);
    assign instr_done   = ((state == S_EXEC1) && !bus.EXTRA && !is_stp) || (state == S_EXEC2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN_ON_RESET ? S_FETCH : S_PAUSE;
            run_mode    <= RUN_ON_RESET;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            unique case (state)
                S_PAUSE: begin
                    if (bus.halt_req) begin
                        run_mode <= 1'b0;
                    end else if (bus.run) begin
                        state    <= S_FETCH;
                        run_mode <= 1'b1;
                    end else if (bus.step) begin
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state    <= S_EXEC1;
                    run_mode <= run_mode_nxt;
                end
                S_EXEC1: begin
                    if (is_stp) begin
                        state    <= S_HALT;
                        run_mode <= 1'b0;
                    end else begin
                        run_mode <= run_mode_nxt;
                        if (bus.EXTRA)
                            state <= S_EXEC2;
                        else
                            state <= run_mode_nxt ? S_FETCH : S_PAUSE;
                    end
                end
                S_EXEC2: begin
                    run_mode <= run_mode_nxt;
                    state    <= run_mode_nxt ? S_FETCH : S_PAUSE;
                end
                S_HALT: begin
                    state    <= S_HALT;
                    run_mode <= 1'b0;
                end
                default: begin
                    state    <= S_PAUSE;
                    run_mode <= 1'b0;
                end
            endcase

            if (instr_done)
                instr_count <= instr_count + 1'b1;
            if (active && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;
        end
    end

    assign bus.PAUSED      = state[0];
    assign bus.FETCH       = state[1];
    assign bus.EXEC1       = state[2];
    assign bus.EXEC2       = state[3];
    assign bus.HALTED      = state[4];
    assign bus.instr_done  = instr_done;
    assign bus.cycle_count = cycle_count;
    assign bus.instr_count = instr_count;

endmodule
